// File: rtl/queue_tx_pkg.sv
// Shared types and line levels for the queue TX serializer.
// Used by queue_tx_serializer; the PARITY state is only reached when QUEUE_TX_PARITY_EN is defined.
package queue_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and
// pulses bit_end in the last cycle of each bit. Held at 0 while run is low.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bit_end = run && (cnt_q == LAST);

endmodule

// File: rtl/queue_tx_serializer.sv
// Pops bytes from the byte queue and sends them as start/data(LSB first)/stop frames.
// Define QUEUE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module queue_tx_serializer
  import queue_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              q_empty,
  input  logic [DATA_W-1:0] q_data,
  output logic              q_rd,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              run, bit_end;
`ifdef QUEUE_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign run = (state_q == START) || (state_q == DATA) ||
               (state_q == PARITY) || (state_q == STOP);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && !q_empty) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (bit_end) state_d = DATA;
`ifdef QUEUE_TX_PARITY_EN
      DATA:    if (bit_end && (bit_q == BIT_LAST)) state_d = PARITY;
      PARITY:  if (bit_end) state_d = STOP;
`else
      DATA:    if (bit_end && (bit_q == BIT_LAST)) state_d = STOP;
`endif
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_rd = (state_q == FETCH);
    busy = (state_q != IDLE);
    done = (state_q == STOP) && bit_end;
    tx   = TX_IDLE_LVL;
    case (state_q)
      START:   tx = TX_START_LVL;
      DATA:    tx = sh_q[0];
`ifdef QUEUE_TX_PARITY_EN
      PARITY:  tx = par_q;
`endif
      default: tx = TX_IDLE_LVL;
    endcase
  end

  // Shift register, bit counter and parity advance together at each data bit boundary.
  always_comb begin
    sh_d  = sh_q;
    bit_d = bit_q;
`ifdef QUEUE_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == LOAD) begin
      sh_d  = q_data;
      bit_d = '0;
`ifdef QUEUE_TX_PARITY_EN
      par_d = 1'b0;
`endif
    end else if ((state_q == DATA) && bit_end) begin
      sh_d  = sh_q >> 1;
      bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
`ifdef QUEUE_TX_PARITY_EN
      par_d = par_q ^ sh_q[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      bit_q <= '0;
`ifdef QUEUE_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      sh_q  <= sh_d;
      bit_q <= bit_d;
`ifdef QUEUE_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_queue_tx_serializer.sv
// Directed self-checking bench for queue_tx_serializer (CLKS_PER_BIT = 4).
// Also covers the parity variant when QUEUE_TX_PARITY_EN is defined.
module tb_queue_tx_serializer;

  localparam int CPB = 4;
`ifdef QUEUE_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       q_empty;
  logic [7:0] q_data;
  logic       q_rd, tx, busy, done;

  int         checks = 0;
  int         errors = 0;
  int         rd_cnt = 0;
  logic [7:0] fifo[$];

  queue_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .q_empty (q_empty),
    .q_data  (q_data),
    .q_rd    (q_rd),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle step; queue model answers a pop with data in the following cycle.
  task automatic tick();
    @(negedge clk);
    if (q_rd === 1'b1) begin
      rd_cnt++;
      if (fifo.size() > 0) q_data = fifo.pop_front();
    end
    q_empty = (fifo.size() == 0);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if ((k == 9) && (NBITS == 11)) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_rd(output int waited);
    waited = 0;
    while ((q_rd !== 1'b1) && (waited < 400)) begin
      tick();
      waited++;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input string tag, input int drop_at,
                           output int waited, output logic [11:0] cap);
    wait_rd(waited);
    chk({tag, "_rd"}, q_rd, 1'b1);
    tick();
    chk({tag, "_rd_pulse"}, q_rd, 1'b0);
    chk({tag, "_load_tx"}, tx, 1'b1);
    chk({tag, "_load_busy"}, busy, 1'b1);
    tick();
    cap = '0;
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if ((k * CPB + c) == drop_at) enable = 1'b0;
        chk({tag, "_tx"}, tx, exp_bit(b, k));
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_done"}, done, ((k == NBITS - 1) && (c == CPB - 1)) ? 1'b1 : 1'b0);
        chk({tag, "_rd_mid"}, q_rd, 1'b0);
        if (c == CPB / 2) cap[k] = tx;
        tick();
      end
    end
    chk({tag, "_end_tx"}, tx, 1'b1);
    chk({tag, "_end_busy"}, busy, 1'b0);
    chk({tag, "_end_done"}, done, 1'b0);
  endtask

  initial begin
    int         w;
    int         rd_ref;
    logic [11:0] cap;

    rst     = 1'b0;
    enable  = 1'b1;
    q_empty = 1'b1;
    q_data  = 8'h00;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_rd", q_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;

    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_tx", tx, 1'b1);
      chk("idle_rd", q_rd, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // single byte 0xA5
    rd_ref = rd_cnt;
    fifo.push_back(8'hA5);
    run_frame(8'hA5, "a5", -1, w, cap);
`ifdef QUEUE_TX_PARITY_EN
    chk("a5_bits", cap[10:0], 11'b10101001010);
`else
    chk("a5_bits", cap[9:0], 10'b1101001010);
`endif
    chk("a5_rd_count", rd_cnt - rd_ref, 1);

    // back-to-back 0x00 then 0xFF
    rd_ref = rd_cnt;
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    run_frame(8'h00, "b00", -1, w, cap);
    run_frame(8'hFF, "bff", -1, w, cap);
    chk("b2b_gap", w, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("b2b_idle_busy", busy, 1'b0);
      chk("b2b_idle_tx", tx, 1'b1);
    end
    chk("b2b_rd_count", rd_cnt - rd_ref, 2);

    // enable dropped mid-frame; queued byte waits for enable
    fifo.push_back(8'h3C);
    fifo.push_back(8'h81);
    run_frame(8'h3C, "e3c", 18, w, cap);
    rd_ref = rd_cnt;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("en_hold_rd", q_rd, 1'b0);
      chk("en_hold_busy", busy, 1'b0);
    end
    chk("en_hold_count", rd_cnt - rd_ref, 0);
    enable = 1'b1;
    run_frame(8'h81, "e81", -1, w, cap);
    chk("en_resume_fast", (w <= 3) ? 1'b1 : 1'b0, 1'b1);

    // reset asserted during data bit 3 of 0x52 (bit 3 = 0)
    fifo.push_back(8'h52);
    wait_rd(w);
    chk("rm_rd", q_rd, 1'b1);
    for (int i = 0; i < 19; i++) tick();
    chk("rm_pre_tx", tx, 1'b0);
    chk("rm_pre_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rm_tx", tx, 1'b1);
    chk("rm_busy", busy, 1'b0);
    chk("rm_rd0", q_rd, 1'b0);
    tick(); tick();
    rst = 1'b1;
    rd_ref = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rm_idle_busy", busy, 1'b0);
      chk("rm_idle_tx", tx, 1'b1);
    end
    chk("rm_no_pop", rd_cnt - rd_ref, 0);
    fifo.push_back(8'h11);
    run_frame(8'h11, "r11", -1, w, cap);
    chk("rm_one_pop", rd_cnt - rd_ref, 1);

`ifdef QUEUE_TX_PARITY_EN
    fifo.push_back(8'h07);
    run_frame(8'h07, "p07", -1, w, cap);
    chk("p07_parity", cap[9], 1'b1);
    fifo.push_back(8'h03);
    run_frame(8'h03, "p03", -1, w, cap);
    chk("p03_parity", cap[9], 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_tx_serializer.md
# queue_tx_serializer

Downstream consumer for the 8-bit byte queue. It pops one byte at a time from the queue's read port and shifts it out on a single-wire asynchronous serial line: start bit, data LSB first, optional parity, stop bit. It sits between the queue's read side and the board-level TX pin and owns all read strobing of the queue.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 2.
- `DATA_W`, default 8: data width. Must match the queue word width.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: when low, no new frame starts. A frame already in progress completes.
- `q_empty`, input, 1: empty flag from the queue.
- `q_data`, input, `DATA_W`: queue read data. Valid in the cycle after `q_rd` is high.
- `q_rd`, output, 1: one-cycle pop strobe to the queue.
- `tx`, output, 1: serial line. Idles high.
- `busy`, output, 1: high from the FETCH state through the last STOP cycle.
- `done`, output, 1: one-cycle pulse in the last cycle of STOP.

## Operation
- Reset (`rst` = 0, takes effect immediately): state = IDLE, `tx` = 1, `q_rd` = 0, `busy` = 0, `done` = 0, all counters 0. Reset mid-frame abandons the frame and does not re-pop the byte.
- States: IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE**: if `enable` and `!q_empty` at the clock edge, go to FETCH. Otherwise stay.
- **FETCH** (1 cycle): `q_rd` = 1. This is the only state that asserts `q_rd`.
- **LOAD** (1 cycle): capture `q_data` into the shift register. Clear the parity accumulator.
- **START**: `tx` = 0 for `CLKS_PER_BIT` cycles.
- **DATA**:
  - `tx` = shift register bit 0, held for `CLKS_PER_BIT` cycles.
  - The register shifts right at each bit boundary.
  - The bit counter (width `$clog2(DATA_W)`) counts 0..`DATA_W`-1, then the block exits DATA.
- **PARITY** (only with `PARITY_EN`): `tx` = XOR of all data bits (even parity) for `CLKS_PER_BIT` cycles.
- **STOP**:
  - `tx` = 1 for `CLKS_PER_BIT` cycles.
  - `done` = 1 in the last cycle.
  - Next state is always IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 within each bit and wraps to 0 at each bit boundary. It is held at 0 in IDLE, FETCH and LOAD.
- `enable` deasserted mid-frame: no effect until the block returns to IDLE.
- `q_empty` is only sampled in IDLE. A byte arriving during a frame is picked up in the first IDLE cycle after that frame.

## Timing
- Cycle numbering, with `q_empty` falling so that it is sampled low at edge 0:
  - FETCH is cycle 1, which is when `q_rd` is high.
  - LOAD is cycle 2.
  - The first START cycle is cycle 3.
- Frame length is `(DATA_W + 2) * CLKS_PER_BIT` cycles without parity and `(DATA_W + 3) * CLKS_PER_BIT` cycles with parity.
- Back-to-back frames have 3 idle-high cycles between the end of STOP and the next START (IDLE, FETCH, LOAD).
- With the defaults and no parity, a frame takes 160 cycles and the pop period is 163 cycles.
- All outputs are registered or pure state decodes, so there are no combinational paths from inputs to outputs.

## Configuration
- `QUEUE_TX_PARITY_EN` defined: the PARITY state is compiled in. An even-parity bit is sent between the last data bit and the stop bit.
- `QUEUE_TX_PARITY_EN` undefined:
  - The PARITY state and the parity accumulator are absent.
  - DATA goes directly to STOP.

## Structure
- Shared package `queue_tx_pkg`:
  - state enum `tx_state_t` (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP);
  - line-level constants `TX_IDLE_LVL` = 1 and `TX_START_LVL` = 0.
- Sub-module `baud_tick_gen`:
  - parameterised by `CLKS_PER_BIT`, with inputs `run` and `clk`/`rst`;
  - outputs a one-cycle `bit_end` pulse when the count reaches `CLKS_PER_BIT`-1.
- The top level holds the FSM, the shift register and the bit counter.

## Test plan
- **Reset and idle.** Hold `rst` low, then release with `q_empty` = 1 for 50 cycles → `tx` = 1, `q_rd` = 0, `busy` = 0 throughout.
- **Single byte.** `CLKS_PER_BIT` = 4, byte 0xA5, `q_empty` falls → `q_rd` is pulsed for exactly 1 cycle, 2 cycles later `tx` shows 0,1,0,1,0,0,1,0,1,1 at 4 cycles each, and `done` pulses once.
- **Back-to-back.** Two bytes 0x00 then 0xFF queued → two frames with exactly 3 high cycles between them and exactly 2 `q_rd` pulses. Then `q_empty` = 1 → the block stays in IDLE.
- **Enable gating.** Drop `enable` in the middle of a 0x3C frame → that frame completes. With the queue non-empty, no `q_rd` occurs until `enable` = 1 again.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 → `tx` = 1 and `busy` = 0 immediately (no clock edge needed). After release the block is idle and does not pop until the queue is sampled non-empty.
- **Parity build.** With `QUEUE_TX_PARITY_EN` defined, byte 0x07 → parity bit = 1 and the frame is 11 bits × 4 = 44 cycles. Byte 0x03 → parity bit = 0.
